alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the combinational ALU port (cm/num1/num2 -> num3/FL). Accepts one
//  conditional instruction per handshake, reads operands from an 8x32 register file, drives
//  the ALU, evaluates the condition against the stored NZCV flags, writes back and reports.
// PARAMETERS
//  DW    32  datapath width; must match ALU num1/num2/num3
//  RA    3   register address width; register file depth = 2**RA
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    synchronous reset, active-high
//  in_valid    in   1    instruction valid
//  in_ready    out  1    block can accept (high only in IDLE)
//  in_cond     in   4    condition code (0 EQ .. 14 AL, 15 NV)
//  in_cm       in   4    ALU opcode: 0 AND,1 XOR,2 SUB,3 RSB,4 ADD,10 CMP,12 OR
//  in_s        in   1    update flags on execute
//  in_rd/rn/rm in   RA   dest / operand1 / operand2 register
//  cfg_we      in   1    register preload write enable
//  cfg_addr    in   RA   preload address
//  cfg_data    in   DW   preload data
//  alu_cm      out  4    to ALU cm
//  alu_num1    out  DW   to ALU num1 (= R[rn])
//  alu_num2    out  DW   to ALU num2 (= R[rm])
//  alu_num3    in   DW   ALU result
//  alu_fl      in   4    ALU flags {N,Z,C,V}
//  out_valid   out  1    response valid
//  out_ready   in   1    response consumed
//  out_result  out  DW   captured alu_num3 (captured even when not executed)
//  out_flags   out  4    flag register after the instruction
//  out_exec    out  1    condition passed and opcode legal
//  out_err     out  1    opcode not in supported set
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE; all outputs 0 (in_ready=1 after reset cycle);
//    flag register 0; all registers 0. Reset mid-operation aborts: no writeback, no flag update.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE. Accept = IDLE & in_valid (in_ready=1 in IDLE only).
//  - Accept cycle: latch cond/cm/s/rd; latch op1=R[rn], op2=R[rm] from pre-edge contents
//    (a cfg write in the same cycle is not visible). alu_* outputs are registered from latches.
//  - ISSUE (1 cycle): ALU settles; at end of cycle capture alu_num3, alu_fl; evaluate cond on
//    OLD flags: EQ Z,NE !Z,CS C,CC !C,MI N,PL !N,VS V,VC !V,HI C&!Z,LS !C|Z,GE N==V,
//    LT N!=V,GT !Z&N==V,LE Z|N!=V,AL 1,NV 0.
//  - Same edge, if exec: cm!=10 -> R[rd]<=alu_num3; (s | cm==10) -> flags<=alu_fl.
//    Illegal cm: out_err=1, exec=0, no write, no flag change (ALU returns 0 anyway).
//  - RESP: out_valid=1, payload stable until out_ready; on out_valid&out_ready -> IDLE,
//    out_valid=0 next cycle. Latency accept->out_valid = 2 cycles; throughput 1 per 3 min.
//  - cfg_we honoured in every state; same-edge collision with writeback to same address:
//    writeback wins; different addresses both commit.
//  - Flag bits stored verbatim from ALU (C semantics are the ALU's, e.g. borrow on SUB).
// STRUCTURE
//  - alu_pkg: opcode localparams, cond code localparams, flag bit indices
//    (N=3,Z=2,C=1,V=0), FSM state enum.
//  - Sub-module cond_eval (combinational: cond[3:0], flags[3:0] -> pass).
//  - Register file, FSM and capture registers inline.
// TESTING
//  - Preload R1=5,R2=3; ADD AL s=1 rd=3 -> out_valid 2 cycles after accept, R3=8,
//    out_flags=0000, out_exec=1.
//  - R1=3,R2=5; CMP AL -> R[rd] unchanged, flags Z=0,C=1 (3<5), N=1; then SUB EQ rd=4 ->
//    out_exec=0, R4 unchanged, out_result still captured.
//  - R1=R2=0x7FFFFFFF; ADD AL s=1 -> result 0xFFFFFFFE, N=1,V=1; s=0 repeat -> flags unchanged.
//  - in_cm=7 -> out_err=1, out_exec=0, no writeback; hold out_ready=0 5 cycles -> payload
//    stable, in_ready=0 throughout.
//  - cfg_we to rd on writeback edge -> R[rd]=ALU result; rst asserted in ISSUE -> no write,
//    flags 0, out_valid=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, condition-code and flag-index constants plus the issue FSM state type
// for the conditional ALU issue controller.
package alu_pkg;

    localparam logic [3:0] CM_AND = 4'd0;
    localparam logic [3:0] CM_XOR = 4'd1;
    localparam logic [3:0] CM_SUB = 4'd2;
    localparam logic [3:0] CM_RSB = 4'd3;
    localparam logic [3:0] CM_ADD = 4'd4;
    localparam logic [3:0] CM_CMP = 4'd10;
    localparam logic [3:0] CM_OR  = 4'd12;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int unsigned FL_N = 3;
    localparam int unsigned FL_Z = 2;
    localparam int unsigned FL_C = 1;
    localparam int unsigned FL_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // True for opcodes the ALU actually implements.
    function automatic logic cm_legal(input logic [3:0] cm);
        case (cm)
            CM_AND, CM_XOR, CM_SUB, CM_RSB, CM_ADD, CM_CMP, CM_OR: cm_legal = 1'b1;
            default:                                               cm_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check of a 4-bit cond against stored {N,Z,C,V} flags.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    always_comb begin
        n    = flags[FL_N];
        z    = flags[FL_Z];
        c    = flags[FL_C];
        v    = flags[FL_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one conditional instruction at a time to an external combinational ALU,
// owns the register file and NZCV flags, and returns a held response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RA = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cond,
    input  logic [3:0]    in_cm,
    input  logic          in_s,
    input  logic [RA-1:0] in_rd,
    input  logic [RA-1:0] in_rn,
    input  logic [RA-1:0] in_rm,
    input  logic          cfg_we,
    input  logic [RA-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic [3:0]    alu_cm,
    output logic [DW-1:0] alu_num1,
    output logic [DW-1:0] alu_num2,
    input  logic [DW-1:0] alu_num3,
    input  logic [3:0]    alu_fl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [3:0]    out_flags,
    output logic          out_exec,
    output logic          out_err
);

    localparam int unsigned NREG = 2 ** RA;

    state_t        state;
    logic [DW-1:0] regs [NREG];
    logic [3:0]    cond_q;
    logic          s_q;
    logic [RA-1:0] rd_q;
    logic [3:0]    flags_q;
    logic          pass_c;
    logic          legal_c;
    logic          exec_c;

    // Condition is judged on the flags as they stood before this instruction.
    cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (flags_q),
        .pass  (pass_c)
    );

    assign legal_c = cm_legal(alu_cm);
    assign exec_c  = pass_c & legal_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            alu_cm     <= '0;
            alu_num1   <= '0;
            alu_num2   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_exec   <= 1'b0;
            out_err    <= 1'b0;
            cond_q     <= '0;
            s_q        <= 1'b0;
            rd_q       <= '0;
            flags_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[RA'(i)] <= '0;
            end
        end else begin
            // Preload first so a same-address writeback below overrides it.
            if (cfg_we) begin
                regs[cfg_addr] <= cfg_data;
            end
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_ISSUE;
                        in_ready <= 1'b0;
                        cond_q   <= in_cond;
                        s_q      <= in_s;
                        rd_q     <= in_rd;
                        alu_cm   <= in_cm;
                        alu_num1 <= regs[in_rn];
                        alu_num2 <= regs[in_rm];
                    end
                end
                ST_ISSUE: begin
                    state      <= ST_RESP;
                    out_valid  <= 1'b1;
                    out_result <= alu_num3;
                    out_exec   <= exec_c;
                    out_err    <= !legal_c;
                    if (exec_c && (alu_cm != CM_CMP)) begin
                        regs[rd_q] <= alu_num3;
                    end
                    if (exec_c && (s_q || (alu_cm == CM_CMP))) begin
                        flags_q   <= alu_fl;
                        out_flags <= alu_fl;
                    end else begin
                        out_flags <= flags_q;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl with a behavioural ALU and
// a register-file/flag reference model.
module tb_alu_issue_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned RA = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_cond;
    logic [3:0]    in_cm;
    logic          in_s;
    logic [RA-1:0] in_rd;
    logic [RA-1:0] in_rn;
    logic [RA-1:0] in_rm;
    logic          cfg_we;
    logic [RA-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [3:0]    alu_cm;
    logic [DW-1:0] alu_num1;
    logic [DW-1:0] alu_num2;
    logic [DW-1:0] alu_num3;
    logic [3:0]    alu_fl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [3:0]    out_flags;
    logic          out_exec;
    logic          out_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mr [8];
    logic [3:0]  mf;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DW(DW), .RA(RA)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cond    (in_cond),
        .in_cm      (in_cm),
        .in_s       (in_s),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .alu_cm     (alu_cm),
        .alu_num1   (alu_num1),
        .alu_num2   (alu_num2),
        .alu_num3   (alu_num3),
        .alu_fl     (alu_fl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_exec   (out_exec),
        .out_err    (out_err)
    );

    function automatic logic is_legal(input logic [3:0] cm);
        return cm inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12};
    endfunction

    // Behavioural ALU: returns {N,Z,C,V,result}; C is borrow for subtracts.
    function automatic logic [35:0] alu_f(input logic [3:0] cm, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        c;
        logic        v;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (cm)
            4'd0:  r = a & b;
            4'd1:  r = a ^ b;
            4'd12: r = a | b;
            4'd2, 4'd10: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd3: begin
                r = b - a;
                c = (b < a);
                v = (a[31] != b[31]) && (r[31] != b[31]);
            end
            4'd4: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[31:0];
                c = t[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: r = 32'd0;
        endcase
        if (!is_legal(cm)) return 36'd0;
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {alu_fl, alu_num3} = alu_f(alu_cm, alu_num1, alu_num2);

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        mr[a]    = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // cfg_ph: 0 none, 1 preload on the accept edge, 2 preload on the writeback edge.
    task automatic instr(input logic [3:0] cond, input logic [3:0] cm, input logic s,
                         input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                         input int hold, input int cfg_ph, input logic [2:0] ca,
                         input logic [31:0] cd);
        logic [31:0] o1, o2, er;
        logic [3:0]  afl;
        logic        legal, ex;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_cond  = cond;
        in_cm    = cm;
        in_s     = s;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        if (cfg_ph == 1) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
        end
        o1 = mr[rn];
        o2 = mr[rm];
        {afl, er} = alu_f(cm, o1, o2);
        legal = is_legal(cm);
        ex = legal && cond_ok(cond, mf);
        if (cfg_ph == 1) mr[ca] = cd;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("issue_in_ready", in_ready, 0);
        chk("issue_out_valid", out_valid, 0);
        chk("issue_alu_cm", alu_cm, cm);
        chk("issue_alu_num1", alu_num1, o1);
        chk("issue_alu_num2", alu_num2, o2);
        if (cfg_ph == 2) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
            mr[ca] = cd;
        end
        if (ex && cm != 4'd10) mr[rd] = er;
        if (ex && (s || cm == 4'd10)) mf = afl;
        @(negedge clk);
        cfg_we = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            chk("resp_out_valid", out_valid, 1);
            chk("resp_in_ready", in_ready, 0);
            chk("resp_result", out_result, er);
            chk("resp_flags", out_flags, mf);
            chk("resp_exec", out_exec, ex);
            chk("resp_err", out_err, !legal);
            if (i < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_out_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [3:0] legal_ops [7];
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12};
        rst = 1'b1; in_valid = 1'b0; in_cond = '0; in_cm = '0; in_s = 1'b0;
        in_rd = '0; in_rn = '0; in_rm = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) mr[i] = 32'd0;
        mf = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_exec", out_exec, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_alu_cm", alu_cm, 0);
        chk("rst_alu_num1", alu_num1, 0);
        rst = 1'b0;

        // ADD AL with flag update, then read R3 back through R3+R0.
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd3);
        instr(4'd14, 4'd4, 1'b1, 3'd3, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0);
        instr(4'd14, 4'd4, 1'b0, 3'd6, 3'd3, 3'd0, 0, 0, 3'd0, 32'd0);

        // CMP sets flags without writeback; SUB EQ then fails its condition.
        preload(3'd1, 32'd3);
        preload(3'd2, 32'd5);
        instr(4'd14, 4'd10, 1'b0, 3'd7, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0);
        instr(4'd0, 4'd2, 1'b1, 3'd4, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0);
        instr(4'd14, 4'd4, 1'b0, 3'd6, 3'd4, 3'd7, 0, 0, 3'd0, 32'd0);

        // Signed overflow, then a flagless SUB leaves NZCV untouched.
        preload(3'd1, 32'h7FFF_FFFF);
        preload(3'd2, 32'h7FFF_FFFF);
        instr(4'd14, 4'd4, 1'b1, 3'd3, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0);
        instr(4'd14, 4'd2, 1'b0, 3'd3, 3'd1, 3'd2, 1, 0, 3'd0, 32'd0);

        // Illegal opcode with back-pressure.
        instr(4'd14, 4'd7, 1'b1, 3'd5, 3'd1, 3'd2, 5, 0, 3'd0, 32'd0);

        // Preload/writeback collisions and accept-edge preload invisibility.
        instr(4'd14, 4'd4, 1'b0, 3'd5, 3'd1, 3'd2, 0, 2, 3'd5, 32'hDEAD_BEEF);
        instr(4'd14, 4'd4, 1'b0, 3'd5, 3'd1, 3'd0, 0, 2, 3'd6, 32'h1234_5678);
        instr(4'd14, 4'd4, 1'b0, 3'd7, 3'd5, 3'd6, 0, 0, 3'd0, 32'd0);
        instr(4'd14, 4'd4, 1'b0, 3'd7, 3'd1, 3'd0, 0, 1, 3'd1, 32'h0000_0111);
        instr(4'd14, 4'd12, 1'b0, 3'd7, 3'd1, 3'd0, 0, 0, 3'd0, 32'd0);

        // Reset while in ISSUE aborts the instruction and clears state.
        @(negedge clk);
        in_valid = 1'b1; in_cond = 4'd14; in_cm = 4'd4; in_s = 1'b1;
        in_rd = 3'd5; in_rn = 3'd1; in_rm = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mr[i] = 32'd0;
        mf = 4'd0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_flags", out_flags, 0);
        instr(4'd14, 4'd4, 1'b0, 3'd6, 3'd1, 3'd5, 0, 0, 3'd0, 32'd0);

        // Randomized instruction stream against the reference model.
        for (int k = 0; k < 60; k++) begin
            logic [3:0] cm;
            if ($urandom_range(0, 3) == 0)
                preload(3'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 7) == 0) cm = 4'($urandom_range(0, 15));
            else cm = legal_ops[$urandom_range(0, 6)];
            instr(4'($urandom_range(0, 15)), cm, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
